usb_bit_unstuff_deser: RTL

Parametrised receive-path bit unstuffer and deserialiser for the SIE RX chain. It sits directly after NRZI decoding and consumes one decoded bit per qualified cycle. It removes the stuffed bit after every run of `RUN_LEN` consecutive ones and flags a stuffing violation. It packs the surviving bits LSB-first into `DATA_W`-bit words for the packet-level logic.

---
 rtl/usb_bit_unstuff_deser_if.sv | 32 +++
 rtl/usb_bit_unstuff_deser.sv | 65 ++++++
 2 files changed

// File: rtl/usb_bit_unstuff_deser_if.sv
// usb_bit_unstuff_deser_if: groups the RX bit-stream inputs and the word/status outputs of the unstuffer
// ports: clear_i, bit_valid_i, data_i (to block); word_o, word_valid_o, stuff_drop_o, error_o, residue_o (from block)
// USB_UNSTUFF_STATS_EN adds stuff_cnt_o (16-bit dropped stuff-bit count)
interface usb_bit_unstuff_deser_if #(
  parameter int DATA_W = 8
);
  logic clear_i;
  logic bit_valid_i;
  logic data_i;
  logic [DATA_W-1:0] word_o;
  logic word_valid_o;
  logic stuff_drop_o;
  logic error_o;
  logic [$clog2(DATA_W)-1:0] residue_o;
`ifdef USB_UNSTUFF_STATS_EN
  logic [15:0] stuff_cnt_o;
`endif
  modport master (
`ifdef USB_UNSTUFF_STATS_EN
    input stuff_cnt_o,
`endif
    output clear_i, bit_valid_i, data_i,
    input word_o, word_valid_o, stuff_drop_o, error_o, residue_o
  );
  modport slave (
`ifdef USB_UNSTUFF_STATS_EN
    output stuff_cnt_o,
`endif
    input clear_i, bit_valid_i, data_i,
    output word_o, word_valid_o, stuff_drop_o, error_o, residue_o
  );
endinterface

// File: rtl/usb_bit_unstuff_deser.sv
// usb_bit_unstuff_deser: removes stuffed bits after RUN_LEN ones and packs surviving bits LSB-first into DATA_W words
// ports: clk12_i bit clock, rst_ni async active-low reset, bus (usb_bit_unstuff_deser_if.slave) stream in / words out
// USB_UNSTUFF_STATS_EN adds a saturating 16-bit count of dropped stuff bits on bus.stuff_cnt_o
module usb_bit_unstuff_deser #(
  parameter int RUN_LEN = 6,
  parameter int DATA_W = 8
) (
  input logic clk12_i,
  input logic rst_ni,
  usb_bit_unstuff_deser_if.slave bus
);
  localparam int RW = $clog2(RUN_LEN + 1);
  localparam int CW = $clog2(DATA_W);
  logic [RW-1:0] run_q, run_d;
  logic [DATA_W-2:0] shift_q, shift_d;
  logic [DATA_W-1:0] word_q, word_d, shifted;
  logic [CW-1:0] residue_q, residue_d;
  logic word_valid_q, word_valid_d, error_q, error_d;
  logic slot, drop, take, last;
  // the shift register only needs the last DATA_W-1 accepted bits; the incoming bit completes the word
  always_comb begin
    slot = run_q == RW'(RUN_LEN);
    drop = bus.bit_valid_i && !bus.clear_i && slot;
    take = bus.bit_valid_i && !bus.clear_i && !slot;
    last = residue_q == CW'(DATA_W - 1);
    shifted = {bus.data_i, shift_q};
    run_d = bus.clear_i ? '0 : !bus.bit_valid_i ? run_q : !bus.data_i ? '0 : slot ? run_q : run_q + RW'(1);
    shift_d = bus.clear_i ? '0 : take ? shifted[DATA_W-1:1] : shift_q;
    residue_d = bus.clear_i ? '0 : !take ? residue_q : last ? '0 : residue_q + CW'(1);
    word_d = (take && last) ? shifted : word_q;
    word_valid_d = take && last;
    error_d = bus.clear_i ? 1'b0 : error_q | (drop & bus.data_i);
  end
  always_ff @(posedge clk12_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q <= '0;
      shift_q <= '0;
      residue_q <= '0;
      word_q <= '0;
      word_valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      run_q <= run_d;
      shift_q <= shift_d;
      residue_q <= residue_d;
      word_q <= word_d;
      word_valid_q <= word_valid_d;
      error_q <= error_d;
    end
  end
  assign bus.stuff_drop_o = drop;
  assign bus.word_o = word_q;
  assign bus.word_valid_o = word_valid_q;
  assign bus.error_o = error_q;
  assign bus.residue_o = residue_q;
`ifdef USB_UNSTUFF_STATS_EN
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = bus.clear_i ? '0 : (drop && cnt_q != 16'hffff) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk12_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign bus.stuff_cnt_o = cnt_q;
`endif
endmodule
